// File: rtl/aes_cipher_iter_pkg.sv
// Shared AES definitions: FSM state type, round-count helper, byte-level round
// functions and the FIPS-197 example vectors used by benches.
package aes_cipher_iter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } state_e;

   function automatic int nr_of(input int nk);
      return nk + 6;
   endfunction

   localparam logic [127:0] FIPS_PT    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] FIPS_CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] FIPS_CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

   // Forward S-box, entry 0 in the top byte.
   localparam logic [2047:0] SBOX_TAB = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TAB[{~x, 3'b111} -: 8];
   endfunction

   // Byte k of the state sits at index 15-k, i.e. byte 0 in bits [127:120].
   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [15:0][7:0] a;
      logic [15:0][7:0] o;
      a = s;
      for (int i = 0; i < 16; i++) o[i] = sbox(a[i]);
      return o;
   endfunction

   // Row r of column c is state byte 4*c+r; row r rotates left by r columns.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [15:0][7:0] a;
      logic [15:0][7:0] o;
      a = s;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[15 - (4 * c + r)] = a[15 - (4 * ((c + r) % 4) + r)];
      return o;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
   endfunction

   function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
      return s ^ k;
   endfunction

   function automatic logic [127:0] encrypt_round(input logic [127:0] s, input logic [127:0] k);
      return add_round_key(mix_columns(shift_rows(sub_bytes(s))), k);
   endfunction

endpackage

// File: rtl/aes_cipher_iter_if.sv
// Block-level handshake bundle for the iterative AES core: plaintext in,
// ciphertext out, plus a busy indicator.
interface aes_cipher_iter_if;

   // A block moves on a rising edge where valid and ready are both high. The
   // source holds valid and its data steady until that edge; ready comes only
   // from registered state and never waits on valid.
   logic         in_valid;
   logic         in_ready;
   logic [127:0] din;
   logic         busy;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] dout;

   modport master (
      output in_valid, din, out_ready,
      input  in_ready, busy, out_valid, dout
   );

   modport slave (
      input  in_valid, din, out_ready,
      output in_ready, busy, out_valid, dout
   );

endinterface

// File: rtl/aes_cipher_iter_final_round.sv
// Last AES round: SubBytes, ShiftRows and AddRoundKey with no MixColumns.
// Identical for every key size.
module aes_cipher_iter_final_round
   import aes_cipher_iter_pkg::*;
(
   input  logic [127:0] state,
   input  logic [127:0] round_key,
   output logic [127:0] result
);

   assign result = add_round_key(shift_rows(sub_bytes(state)), round_key);

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption core: one round per clock over an externally
// supplied expanded key schedule, one block in flight at a time.
module aes_cipher_iter
   import aes_cipher_iter_pkg::*;
#(
   parameter  int Nk = 4,
   localparam int Nr = nr_of(Nk)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [(Nr+1)*128-1:0] w,
   aes_cipher_iter_if.slave      bus,
   output state_e                dbg_state
);

   localparam int CW = $clog2(Nr + 1);

   if (Nk != 4 && Nk != 6 && Nk != 8) begin : g_bad_nk
      $error("aes_cipher_iter: Nk must be 4, 6 or 8");
   end

   state_e        st;
   logic [CW-1:0] round_cnt;
   logic [127:0]  state_q;
   logic [127:0]  dout_q;
   logic          in_ready_q;
   logic          busy_q;
   logic          out_valid_q;

   logic [127:0]  rk [Nr+1];
   logic [127:0]  round_key;
   logic [127:0]  mid_res;
   logic [127:0]  fin_res;

   // Round key 0 occupies the MSBs of the schedule.
   for (genvar r = 0; r <= Nr; r++) begin : g_rk
      assign rk[r] = w[(Nr+1)*128-1-r*128 -: 128];
   end

   always_comb begin
      round_key = rk[round_cnt];
      mid_res   = encrypt_round(state_q, round_key);
   end

   aes_cipher_iter_final_round u_final (
      .state     (state_q),
      .round_key (round_key),
      .result    (fin_res)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st          <= IDLE;
         round_cnt   <= '0;
         state_q     <= '0;
         dout_q      <= '0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (st)
            IDLE: begin
               if (bus.in_valid) begin
                  state_q    <= bus.din ^ rk[0];
                  round_cnt  <= CW'(1);
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  st         <= ROUND;
               end
            end
            ROUND: begin
               if (round_cnt == CW'(Nr)) begin
                  dout_q      <= fin_res;
                  out_valid_q <= 1'b1;
                  st          <= DONE;
               end else begin
                  state_q   <= mid_res;
                  round_cnt <= round_cnt + 1'b1;
               end
            end
            DONE: begin
               // in_ready returns one cycle after the output handshake, so
               // acceptance never overlaps with delivery.
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
                  st          <= IDLE;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.busy      = busy_q;
   assign bus.out_valid = out_valid_q;
   assign bus.dout      = dout_q;
   assign dbg_state     = st;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Bench for aes_cipher_iter: AES-128/192/256 instances checked against an
// independent GF(2^8) matrix model, with a queue-based scoreboard per instance.
module tb_aes_cipher_iter;
   import aes_cipher_iter_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;
   int   cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUTs ----------------
   aes_cipher_iter_if i4 ();
   aes_cipher_iter_if i6 ();
   aes_cipher_iter_if i8 ();

   logic [1919:0] wf [3];
   logic [1407:0] w4;
   logic [1663:0] w6;
   logic [1919:0] w8;
   state_e        dbg4, dbg6, dbg8;
   logic          ordy [3];
   logic          bp_rand = 1'b0;

   assign w4 = wf[0][1919 -: 1408];
   assign w6 = wf[1][1919 -: 1664];
   assign w8 = wf[2];
   assign i4.out_ready = ordy[0];
   assign i6.out_ready = ordy[1];
   assign i8.out_ready = ordy[2];

   aes_cipher_iter #(.Nk(4)) dut4 (.clk(clk), .rst_n(rst_n), .w(w4), .bus(i4), .dbg_state(dbg4));
   aes_cipher_iter #(.Nk(6)) dut6 (.clk(clk), .rst_n(rst_n), .w(w6), .bus(i6), .dbg_state(dbg6));
   aes_cipher_iter #(.Nk(8)) dut8 (.clk(clk), .rst_n(rst_n), .w(w8), .bus(i8), .dbg_state(dbg8));

   // ---------------- scoreboard state ----------------
   logic [127:0] exp_q   [3][$];
   int           exp_t_q [3][$];
   logic         prev_ov [3];
   int           total = 0;
   int           bad   = 0;

   function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, want);
      end
   endfunction

   // ---------------- reference model ----------------
   logic [7:0] sb [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = '0; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [7:0] r;
      r = v;
      for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   // S-box from first principles: multiplicative inverse then affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = '0;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] t);
      return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
   endfunction

   function automatic logic [1919:0] expand(input int nk, input logic [255:0] key);
      logic [31:0]   wd [60];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [1919:0] o;
      int            nw;
      nw = 4 * (nk + 7);
      rc = 8'h01;
      o  = '0;
      for (int i = 0; i < nk; i++) wd[i] = key[255-32*i -: 32];
      for (int i = nk; i < nw; i++) begin
         t = wd[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         wd[i] = wd[i-nk] ^ t;
      end
      for (int i = 0; i < nw; i++) o[1919-32*i -: 32] = wd[i];
      return o;
   endfunction

   function automatic logic [127:0] model_enc(input int nk, input logic [1919:0] wk, input logic [127:0] pt);
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [127:0] o;
      int           nr;
      nr = nk + 6;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            s[r][c] = pt[127-8*(4*c+r) -: 8] ^ wk[1919-8*(4*c+r) -: 8];
      for (int rnd = 1; rnd <= nr; rnd++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               t[r][c] = sb[s[r][(c+r)%4]];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               if (rnd < nr)
                  s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
               else
                  s[r][c] = t[r][c];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               s[r][c] = s[r][c] ^ wk[1919-128*rnd-8*(4*c+r) -: 8];
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[r][c];
      return o;
   endfunction

   function automatic logic [255:0] fips_key(input int nk);
      logic [255:0] k;
      k = '0;
      for (int i = 0; i < 4 * nk; i++) k[255-8*i -: 8] = 8'(i);
      return k;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic int nk_of(input int u);
      return 4 + 2 * u;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_in(input int u, input logic v, input logic [127:0] d);
      case (u)
         0: begin i4.in_valid = v; i4.din = d; end
         1: begin i6.in_valid = v; i6.din = d; end
         default: begin i8.in_valid = v; i8.din = d; end
      endcase
   endtask

   function automatic logic in_ready_of(input int u);
      case (u)
         0: return i4.in_ready;
         1: return i6.in_ready;
         default: return i8.in_ready;
      endcase
   endfunction

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic send(input int u, input logic [127:0] d, input logic [127:0] want, output int acc);
      int n;
      n   = 0;
      acc = -1;
      drive_in(u, 1'b1, d);
      while (!in_ready_of(u) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("accept_wait_u%0d", u), 128'(in_ready_of(u)), 128'(1));
      if (in_ready_of(u)) begin
         acc = cyc + 1;
         exp_q[u].push_back(want);
         exp_t_q[u].push_back(acc + nr_of(nk_of(u)));
      end
      @(negedge clk);
      drive_in(u, 1'b0, '0);
   endtask

   task automatic rand_blocks(input int u, input int cnt);
      logic [127:0] d;
      int           a;
      for (int k = 0; k < cnt; k++) begin
         d = rand128();
         send(u, d, model_enc(nk_of(u), wf[u], d), a);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
   endtask

   task automatic drain();
      int n;
      int pend;
      n    = 0;
      pend = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
      while (pend != 0 && n < 1000) begin
         @(negedge clk);
         n++;
         pend = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
      end
      chk("drain_pending", 128'(pend), 128'(0));
   endtask

   task automatic check_idle(input int u, input string tag);
      logic         ir, ov, bz;
      logic [127:0] dq;
      state_e       ds;
      case (u)
         0: begin ir = i4.in_ready; ov = i4.out_valid; bz = i4.busy; dq = i4.dout; ds = dbg4; end
         1: begin ir = i6.in_ready; ov = i6.out_valid; bz = i6.busy; dq = i6.dout; ds = dbg6; end
         default: begin ir = i8.in_ready; ov = i8.out_valid; bz = i8.busy; dq = i8.dout; ds = dbg8; end
      endcase
      chk($sformatf("%s_in_ready_u%0d", tag, u), 128'(ir), 128'(1));
      chk($sformatf("%s_out_valid_u%0d", tag, u), 128'(ov), 128'(0));
      chk($sformatf("%s_busy_u%0d", tag, u), 128'(bz), 128'(0));
      chk($sformatf("%s_dout_u%0d", tag, u), dq, 128'(0));
      chk($sformatf("%s_state_u%0d", tag, u), 128'(ds), 128'(IDLE));
   endtask

   // ---------------- monitors ----------------
   task automatic mon(input int u, input logic ov, input logic ordy_v, input logic [127:0] dq);
      if (ov) begin
         if (exp_q[u].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out_u%0d: got %h want no output", u, dq);
         end else begin
            if (!prev_ov[u])
               chk($sformatf("latency_u%0d", u), 128'(cyc), 128'(exp_t_q[u][0]));
            chk($sformatf("dout_u%0d", u), dq, exp_q[u][0]);
            if (ordy_v) begin
               void'(exp_q[u].pop_front());
               void'(exp_t_q[u].pop_front());
            end
         end
      end
      prev_ov[u] = ov;
   endtask

   always begin
      @(negedge clk);
      #1;
      mon(0, i4.out_valid, i4.out_ready, i4.dout);
      mon(1, i6.out_valid, i6.out_ready, i6.dout);
      mon(2, i8.out_valid, i8.out_ready, i8.dout);
   end

   always @(negedge clk) if (bp_rand) ordy[0] = 1'($urandom_range(0, 1));

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [127:0] d, d2;
      int           a, a0, a1, a2, h, prev_a;

      rst_n = 1'b0;
      for (int u = 0; u < 3; u++) begin
         ordy[u]    = 1'b1;
         prev_ov[u] = 1'b0;
         drive_in(u, 1'b0, '0);
      end
      build_sbox();
      for (int u = 0; u < 3; u++) wf[u] = expand(nk_of(u), fips_key(nk_of(u)));

      repeat (3) @(negedge clk);
      for (int u = 0; u < 3; u++) check_idle(u, "reset");
      rst_n = 1'b1;

      // FIPS-197 example vectors on all three key sizes at once.
      fork
         send(0, FIPS_PT, FIPS_CT128, a0);
         send(1, FIPS_PT, FIPS_CT192, a1);
         send(2, FIPS_PT, FIPS_CT256, a2);
      join
      drain();

      // Backpressure: output held, a second block offered but refused.
      ordy[0] = 1'b0;
      d  = rand128();
      d2 = rand128();
      send(0, d, model_enc(4, wf[0], d), a);
      h = 0;
      while (!i4.out_valid && h < 100) begin
         @(negedge clk);
         h++;
      end
      chk("bp_out_valid_rise", 128'(i4.out_valid), 128'(1));
      drive_in(0, 1'b1, d2);
      for (int k = 0; k < 5; k++) begin
         chk("bp_in_ready", 128'(i4.in_ready), 128'(0));
         chk("bp_out_valid_hold", 128'(i4.out_valid), 128'(1));
         chk("bp_busy", 128'(i4.busy), 128'(1));
         chk("bp_state", 128'(dbg4), 128'(DONE));
         @(negedge clk);
      end
      ordy[0] = 1'b1;
      h = cyc + 1;
      send(0, d2, model_enc(4, wf[0], d2), a);
      chk("bp_accept_after_handshake", 128'(a), 128'(h + 1));
      drain();

      // Reset while round_cnt is 5: block discarded, core idle, then a clean block.
      d = rand128();
      send(0, d, model_enc(4, wf[0], d), a);
      repeat (4) @(negedge clk);
      chk("mid_busy", 128'(i4.busy), 128'(1));
      chk("mid_in_ready", 128'(i4.in_ready), 128'(0));
      chk("mid_state", 128'(dbg4), 128'(ROUND));
      rst_n = 1'b0;
      exp_q[0].delete();
      exp_t_q[0].delete();
      @(negedge clk);
      check_idle(0, "mid_reset");
      rst_n = 1'b1;
      send(0, FIPS_PT, FIPS_CT128, a);
      drain();

      // Back-to-back with out_ready high: acceptances Nr+2 cycles apart.
      prev_a = 0;
      for (int k = 0; k < 4; k++) begin
         d = rand128();
         send(0, d, model_enc(4, wf[0], d), a);
         if (k > 0) chk($sformatf("b2b_spacing_%0d", k), 128'(a - prev_a), 128'(12));
         prev_a = a;
      end
      drain();

      // Random keys, random data, random backpressure on the 128-bit core.
      for (int u = 0; u < 3; u++) wf[u] = expand(nk_of(u), {rand128(), rand128()});
      fork
         begin
            bp_rand = 1'b1;
            rand_blocks(0, 6);
            bp_rand = 1'b0;
         end
         rand_blocks(1, 3);
         rand_blocks(2, 3);
      join
      @(negedge clk);
      ordy[0] = 1'b1;
      drain();

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
